// File: rtl/pool_cu_gen_if.sv
// Control bundle between the pooling control unit and its neighbouring layers.
// Level handshakes: start_from_previous stays high until this unit leaves idle;
// start_to_next pulses once and only when the next layer reports end_from_next.
interface pool_cu_gen_if #(
  parameter int ADDRESS_SIZE_IFM      = 10,
  parameter int ADDRESS_SIZE_NEXT_IFM = 8
);
  logic                             start_from_previous;
  logic                             end_from_next;
  logic                             end_to_previous;
  logic                             ifm_enable_read;
  logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_read;
  logic                             pool_enable;
  logic                             ifm_enable_write_next;
  logic [ADDRESS_SIZE_NEXT_IFM-1:0] ifm_address_write_next;
  logic                             start_to_next;
  logic                             ifm_sel_next;
  logic [1:0]                       state_dbg;

  modport master (
    input  start_from_previous, end_from_next,
    output end_to_previous, ifm_enable_read, ifm_address_read, pool_enable,
           ifm_enable_write_next, ifm_address_write_next, start_to_next,
           ifm_sel_next, state_dbg
  );

  modport slave (
    output start_from_previous, end_from_next,
    input  end_to_previous, ifm_enable_read, ifm_address_read, pool_enable,
           ifm_enable_write_next, ifm_address_write_next, start_to_next,
           ifm_sel_next, state_dbg
  );
endinterface

// File: rtl/pool_cu_gen.sv
// Pooling-layer control unit: scans one IFM buffer row-major, flags completed
// K x K windows at stride S, writes results onward and hands frames to the next layer.
module pool_cu_gen #(
  parameter int IFM_SIZE              = 28,
  parameter int KERNAL_SIZE           = 2,
  parameter int STRIDE                = 2,
  parameter int READ_LATENCY          = 1,
  parameter int POOL_LATENCY          = 3,
  parameter int IFM_SIZE_NEXT         = (IFM_SIZE - KERNAL_SIZE) / STRIDE + 1,
  parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT)
) (
  input logic           clk,
  input logic           reset,
  pool_cu_gen_if.master bus
);

  localparam int POS_W        = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) : 1;
  localparam int PH_W         = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int DRAIN_CYCLES = READ_LATENCY + POOL_LATENCY;
  localparam int DR_W         = $clog2(DRAIN_CYCLES + 1);

  localparam logic [ADDRESS_SIZE_IFM-1:0]      RD_LAST  = ADDRESS_SIZE_IFM'(IFM_SIZE * IFM_SIZE - 1);
  localparam logic [ADDRESS_SIZE_NEXT_IFM-1:0] WR_LAST  = ADDRESS_SIZE_NEXT_IFM'(IFM_SIZE_NEXT * IFM_SIZE_NEXT - 1);
  localparam logic [POS_W-1:0]                 POS_LAST = POS_W'(IFM_SIZE - 1);
  localparam logic [PH_W-1:0]                  PH_LAST  = PH_W'(STRIDE - 1);
  localparam logic [DR_W-1:0]                  DR_LAST  = DR_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                           state_q, state_d;
  logic [ADDRESS_SIZE_IFM-1:0]      rd_addr;
  logic [POS_W-1:0]                 row, col;
  logic [PH_W-1:0]                  row_ph, col_ph;
  logic [DR_W-1:0]                  drain_cnt;
  logic [READ_LATENCY-1:0]          rd_pipe;
  logic [POOL_LATENCY-1:0]          pool_pipe;
  logic [ADDRESS_SIZE_NEXT_IFM-1:0] wr_addr;
  logic                             pending;
  logic                             stn_q;
  logic                             sel_q;
  logic                             rd_en;
  logic                             etp;
  logic                             detect;
  logic                             pool_en;
  logic                             wr_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    etp     = 1'b0;
    case (state_q)
      IDLE: begin
        etp = ~pending;
        if (bus.start_from_previous && !pending) state_d = READ;
      end
      READ: begin
        rd_en = 1'b1;
        if (rd_addr == RD_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == DR_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Phase counters hold (pos - K + 1) mod S once pos has reached K-1; zero before that.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr   <= '0;
      row       <= '0;
      col       <= '0;
      row_ph    <= '0;
      col_ph    <= '0;
      drain_cnt <= '0;
    end else begin
      if (state_q == READ) begin
        rd_addr <= (rd_addr == RD_LAST) ? '0 : rd_addr + 1'b1;
        if (col == POS_LAST) begin
          col    <= '0;
          col_ph <= '0;
          if (row == POS_LAST) begin
            row    <= '0;
            row_ph <= '0;
          end else begin
            row    <= row + 1'b1;
            if (int'(row) < KERNAL_SIZE - 1) row_ph <= '0;
            else                             row_ph <= (row_ph == PH_LAST) ? '0 : row_ph + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
          if (int'(col) < KERNAL_SIZE - 1) col_ph <= '0;
          else                             col_ph <= (col_ph == PH_LAST) ? '0 : col_ph + 1'b1;
        end
      end
      drain_cnt <= (state_q == DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  assign detect = (state_q == READ) &&
                  (int'(row) >= KERNAL_SIZE - 1) && (int'(col) >= KERNAL_SIZE - 1) &&
                  (row_ph == '0) && (col_ph == '0);

  assign pool_en = rd_pipe[READ_LATENCY-1];
  assign wr_en   = pool_pipe[POOL_LATENCY-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pipe   <= '0;
      pool_pipe <= '0;
    end else begin
      rd_pipe[0]   <= detect;
      pool_pipe[0] <= pool_en;
      for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
      for (int i = 1; i < POOL_LATENCY; i++) pool_pipe[i] <= pool_pipe[i-1];
    end
  end

  // The frame handoff is registered, so the pulse lands one cycle after pending is seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr <= '0;
      pending <= 1'b0;
      stn_q   <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      stn_q <= pending && bus.end_from_next;
      if (pending && bus.end_from_next) begin
        pending <= 1'b0;
        sel_q   <= ~sel_q;
      end
      if (wr_en) begin
        if (wr_addr == WR_LAST) begin
          wr_addr <= '0;
          pending <= 1'b1;
        end else begin
          wr_addr <= wr_addr + 1'b1;
        end
      end
    end
  end

  assign bus.end_to_previous        = etp;
  assign bus.ifm_enable_read        = rd_en;
  assign bus.ifm_address_read       = rd_addr;
  assign bus.pool_enable            = pool_en;
  assign bus.ifm_enable_write_next  = wr_en;
  assign bus.ifm_address_write_next = wr_addr;
  assign bus.start_to_next          = stn_q;
  assign bus.ifm_sel_next           = sel_q;
  assign bus.state_dbg              = state_q;

endmodule

// File: tb/tb_pool_cu_gen.sv
// Directed bench for pool_cu_gen: default 28/2/2 frame, 7/3/2 windowing,
// 4/1/1 passthrough, backpressure, mid-frame reset and back-to-back frames.
module tb_pool_cu_gen;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_q[$];
  logic exp_sel_a = 1'b0;

  pool_cu_gen_if #(.ADDRESS_SIZE_IFM(10), .ADDRESS_SIZE_NEXT_IFM(8)) ifa ();
  pool_cu_gen_if #(.ADDRESS_SIZE_IFM(6),  .ADDRESS_SIZE_NEXT_IFM(4)) ifb ();
  pool_cu_gen_if #(.ADDRESS_SIZE_IFM(4),  .ADDRESS_SIZE_NEXT_IFM(4)) ifc ();

  pool_cu_gen dut_a (.clk(clk), .reset(reset), .bus(ifa));
  pool_cu_gen #(.IFM_SIZE(7), .KERNAL_SIZE(3), .STRIDE(2), .READ_LATENCY(1), .POOL_LATENCY(3))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));
  pool_cu_gen #(.IFM_SIZE(4), .KERNAL_SIZE(1), .STRIDE(1), .READ_LATENCY(1), .POOL_LATENCY(3))
    dut_c (.clk(clk), .reset(reset), .bus(ifc));

  // clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // monitors: pool_q records the read address seen one cycle before each pool strobe
  logic [31:0] rd_q_a[$], pool_q_a[$], wr_q_a[$];
  logic [31:0] pool_q_b[$], wr_q_b[$];
  logic [31:0] pool_q_c[$], wr_q_c[$];
  int stn_a = 0, stn_b = 0, stn_c = 0;
  int orphan_a = 0, orphan_b = 0, orphan_c = 0;
  logic pv_a = 1'b0, pv_b = 1'b0, pv_c = 1'b0;
  logic [31:0] pa_a = '0, pa_b = '0, pa_c = '0;

  always @(negedge clk) begin
    if (ifa.pool_enable) begin if (pv_a) pool_q_a.push_back(pa_a); else orphan_a++; end
    if (ifa.ifm_enable_read) rd_q_a.push_back(32'(ifa.ifm_address_read));
    if (ifa.ifm_enable_write_next) wr_q_a.push_back(32'(ifa.ifm_address_write_next));
    if (ifa.start_to_next) stn_a++;
    pv_a = ifa.ifm_enable_read;
    pa_a = 32'(ifa.ifm_address_read);
  end

  always @(negedge clk) begin
    if (ifb.pool_enable) begin if (pv_b) pool_q_b.push_back(pa_b); else orphan_b++; end
    if (ifb.ifm_enable_write_next) wr_q_b.push_back(32'(ifb.ifm_address_write_next));
    if (ifb.start_to_next) stn_b++;
    pv_b = ifb.ifm_enable_read;
    pa_b = 32'(ifb.ifm_address_read);
  end

  always @(negedge clk) begin
    if (ifc.pool_enable) begin if (pv_c) pool_q_c.push_back(pa_c); else orphan_c++; end
    if (ifc.ifm_enable_write_next) wr_q_c.push_back(32'(ifc.ifm_address_write_next));
    if (ifc.start_to_next) stn_c++;
    pv_c = ifc.ifm_enable_read;
    pa_c = 32'(ifc.ifm_address_read);
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic start_a(output bit ok);
    ok = 1'b0;
    ifa.start_from_previous = 1'b1;
    for (int n = 0; n < 60 && !ok; n++) begin tick(1); ok = ifa.ifm_enable_read; end
    ifa.start_from_previous = 1'b0;
  endtask

  task automatic wait_stn_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin tick(1); ok = ifa.start_to_next; end
  endtask

  task automatic start_b(output bit ok);
    ok = 1'b0;
    ifb.start_from_previous = 1'b1;
    for (int n = 0; n < 60 && !ok; n++) begin tick(1); ok = ifb.ifm_enable_read; end
    ifb.start_from_previous = 1'b0;
  endtask

  task automatic wait_stn_b(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin tick(1); ok = ifb.start_to_next; end
  endtask

  task automatic start_c(output bit ok);
    ok = 1'b0;
    ifc.start_from_previous = 1'b1;
    for (int n = 0; n < 60 && !ok; n++) begin tick(1); ok = ifc.ifm_enable_read; end
    ifc.start_from_previous = 1'b0;
  endtask

  task automatic wait_stn_c(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin tick(1); ok = ifc.start_to_next; end
  endtask

  // scenarios
  task automatic test_reset();
    ifa.start_from_previous = 1'b0; ifa.end_from_next = 1'b0;
    ifb.start_from_previous = 1'b0; ifb.end_from_next = 1'b0;
    ifc.start_from_previous = 1'b0; ifc.end_from_next = 1'b0;
    reset = 1'b1;
    tick(2);
    checks++;
    if (ifa.end_to_previous !== 1'b1) begin
      errors++; $display("FAIL reset_end_to_previous: got %b required 1", ifa.end_to_previous);
    end
    checks++;
    if ({ifa.ifm_enable_read, ifa.ifm_address_read, ifa.pool_enable, ifa.ifm_enable_write_next,
         ifa.ifm_address_write_next, ifa.start_to_next, ifa.ifm_sel_next} !== '0) begin
      errors++; $display("FAIL reset_outputs: got rd=%b ra=%0d pe=%b we=%b wa=%0d stn=%b sel=%b required all 0",
        ifa.ifm_enable_read, ifa.ifm_address_read, ifa.pool_enable, ifa.ifm_enable_write_next,
        ifa.ifm_address_write_next, ifa.start_to_next, ifa.ifm_sel_next);
    end
    checks++;
    if (ifa.state_dbg !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d required 0", ifa.state_dbg);
    end
    reset = 1'b0;
    tick(2);
    checks++;
    if (ifb.end_to_previous !== 1'b1 || ifc.end_to_previous !== 1'b1) begin
      errors++; $display("FAIL reset_idle_bc: got b=%b c=%b required 1 1", ifb.end_to_previous, ifc.end_to_previous);
    end
  endtask

  task automatic test_default_frame();
    bit ok;
    int rb, pb, wb, sb, ob, bad;
    logic [31:0] got;
    ifa.end_from_next = 1'b1;
    rb = rd_q_a.size(); pb = pool_q_a.size(); wb = wr_q_a.size(); sb = stn_a; ob = orphan_a;
    start_a(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL a_start: got read=0 required 1"); end
    wait_stn_a(1200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL a_frame_timeout: got no start_to_next required pulse"); end
    exp_sel_a = ~exp_sel_a;
    tick(3);
    checks++;
    if (rd_q_a.size() - rb !== 784) begin
      errors++; $display("FAIL a_read_count: got %0d required 784", rd_q_a.size() - rb);
    end
    exp_q.delete();
    for (int i = 0; i < 784; i++) exp_q.push_back(32'(i));
    checks++; bad = 0;
    for (int i = 0; i < 784; i++) begin
      got = (rb + i < rd_q_a.size()) ? rd_q_a[rb+i] : 32'hffff_ffff;
      if (got !== exp_q[i]) begin
        if (bad == 0) $display("FAIL a_read_addr[%0d]: got %0d required %0d", i, got, exp_q[i]);
        bad++;
      end
    end
    if (bad != 0) errors++;
    got = (pool_q_a.size() > pb) ? pool_q_a[pb] : 32'hffff_ffff;
    checks++;
    if (got !== 32'd29 || orphan_a !== ob) begin
      errors++; $display("FAIL a_first_pool: got prev_read=%0d orphans=%0d required 29 and %0d", got, orphan_a, ob);
    end
    checks++;
    if (pool_q_a.size() - pb !== 196) begin
      errors++; $display("FAIL a_pool_count: got %0d required 196", pool_q_a.size() - pb);
    end
    exp_q.delete();
    for (int i = 0; i < 196; i++) exp_q.push_back(32'(i));
    checks++; bad = 0;
    if (wr_q_a.size() - wb !== 196) bad++;
    for (int i = 0; i < 196; i++) begin
      got = (wb + i < wr_q_a.size()) ? wr_q_a[wb+i] : 32'hffff_ffff;
      if (got !== exp_q[i]) bad++;
    end
    if (bad != 0) begin
      errors++; $display("FAIL a_write_addr: got %0d writes with %0d bad required 196 on 0..195", wr_q_a.size() - wb, bad);
    end
    checks++;
    if (stn_a - sb !== 1 || ifa.ifm_sel_next !== exp_sel_a) begin
      errors++; $display("FAIL a_handoff: got pulses=%0d sel=%b required 1 and %b", stn_a - sb, ifa.ifm_sel_next, exp_sel_a);
    end
  endtask

  task automatic test_window_7x3x2();
    bit ok;
    int pb, wb, sb, ob, bad;
    logic [31:0] got;
    ifb.end_from_next = 1'b1;
    pb = pool_q_b.size(); wb = wr_q_b.size(); sb = stn_b; ob = orphan_b;
    start_b(ok);
    wait_stn_b(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b_frame_timeout: got no start_to_next required pulse"); end
    tick(3);
    exp_q = '{32'd16, 32'd18, 32'd20, 32'd30, 32'd32, 32'd34, 32'd44, 32'd46, 32'd48};
    checks++; bad = 0;
    if (pool_q_b.size() - pb !== 9 || orphan_b !== ob) bad++;
    for (int i = 0; i < 9; i++) begin
      got = (pb + i < pool_q_b.size()) ? pool_q_b[pb+i] : 32'hffff_ffff;
      if (got !== exp_q[i]) begin
        if (bad == 0) $display("FAIL b_window[%0d]: got read addr %0d required %0d", i, got, exp_q[i]);
        bad++;
      end
    end
    if (bad != 0) begin
      errors++; $display("FAIL b_windows: got %0d strobes required 9 at (2..6 step 2)^2", pool_q_b.size() - pb);
    end
    checks++; bad = 0;
    if (wr_q_b.size() - wb !== 9) bad++;
    for (int i = 0; i < 9; i++) begin
      got = (wb + i < wr_q_b.size()) ? wr_q_b[wb+i] : 32'hffff_ffff;
      if (got !== 32'(i)) bad++;
    end
    if (bad != 0) begin
      errors++; $display("FAIL b_write_addr: got %0d writes with %0d bad required 9 on 0..8", wr_q_b.size() - wb, bad);
    end
    checks++;
    if (stn_b - sb !== 1 || ifb.ifm_sel_next !== 1'b1) begin
      errors++; $display("FAIL b_handoff: got pulses=%0d sel=%b required 1 and 1", stn_b - sb, ifb.ifm_sel_next);
    end
  endtask

  task automatic test_k1_passthrough();
    bit ok;
    int pb, wb, ob, bad;
    logic [31:0] got;
    ifc.end_from_next = 1'b1;
    pb = pool_q_c.size(); wb = wr_q_c.size(); ob = orphan_c;
    start_c(ok);
    wait_stn_c(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL c_frame_timeout: got no start_to_next required pulse"); end
    tick(3);
    checks++; bad = 0;
    if (pool_q_c.size() - pb !== 16 || orphan_c !== ob) bad++;
    for (int i = 0; i < 16; i++) begin
      got = (pb + i < pool_q_c.size()) ? pool_q_c[pb+i] : 32'hffff_ffff;
      if (got !== 32'(i)) bad++;
    end
    if (bad != 0) begin
      errors++; $display("FAIL c_pool_each_read: got %0d strobes with %0d bad required 16, one per read", pool_q_c.size() - pb, bad);
    end
    checks++; bad = 0;
    if (wr_q_c.size() - wb !== 16) bad++;
    for (int i = 0; i < 16; i++) begin
      got = (wb + i < wr_q_c.size()) ? wr_q_c[wb+i] : 32'hffff_ffff;
      if (got !== 32'(i)) bad++;
    end
    if (bad != 0) begin
      errors++; $display("FAIL c_write_addr: got %0d writes with %0d bad required 16 on 0..15", wr_q_c.size() - wb, bad);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int wb, sb, rb2;
    ifa.end_from_next = 1'b0;
    wb = wr_q_a.size(); sb = stn_a;
    start_a(ok);
    for (int n = 0; n < 1200 && (wr_q_a.size() - wb < 196); n++) tick(1);
    tick(6);
    checks++;
    if (ifa.state_dbg !== 2'd0 || ifa.end_to_previous !== 1'b0) begin
      errors++; $display("FAIL bp_pending_idle: got state=%0d etp=%b required 0 and 0", ifa.state_dbg, ifa.end_to_previous);
    end
    rb2 = rd_q_a.size();
    ifa.start_from_previous = 1'b1;
    tick(50);
    checks++;
    if (rd_q_a.size() !== rb2 || stn_a !== sb || ifa.end_to_previous !== 1'b0) begin
      errors++; $display("FAIL bp_hold: got reads=%0d pulses=%0d etp=%b required 0 0 0",
        rd_q_a.size() - rb2, stn_a - sb, ifa.end_to_previous);
    end
    ifa.end_from_next = 1'b1;
    wait_stn_a(10, ok);
    exp_sel_a = ~exp_sel_a;
    checks++;
    if (!ok || ifa.ifm_sel_next !== exp_sel_a) begin
      errors++; $display("FAIL bp_release: got pulse=%b sel=%b required 1 and %b", ok, ifa.ifm_sel_next, exp_sel_a);
    end
    start_a(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_next_read: got read=0 required 1"); end
    wait_stn_a(1200, ok);
    exp_sel_a = ~exp_sel_a;
    tick(3);
    checks++;
    if (stn_a - sb !== 2 || wr_q_a.size() - wb !== 392 || ifa.ifm_sel_next !== exp_sel_a) begin
      errors++; $display("FAIL bp_two_frames: got pulses=%0d writes=%0d sel=%b required 2 392 %b",
        stn_a - sb, wr_q_a.size() - wb, ifa.ifm_sel_next, exp_sel_a);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok, hit;
    int wb, sb;
    ifa.end_from_next = 1'b1;
    start_a(ok);
    hit = 1'b0;
    for (int n = 0; n < 400 && !hit; n++) begin
      tick(1);
      hit = ifa.ifm_enable_read && (ifa.ifm_address_read == 10'd300);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rst_mid_reach300: got no read at 300 required one"); end
    reset = 1'b1;
    #1;
    exp_sel_a = 1'b0;
    checks++;
    if (ifa.end_to_previous !== 1'b1 ||
        {ifa.ifm_enable_read, ifa.ifm_address_read, ifa.pool_enable, ifa.ifm_enable_write_next,
         ifa.ifm_address_write_next, ifa.start_to_next, ifa.ifm_sel_next} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: got etp=%b rd=%b ra=%0d we=%b wa=%0d sel=%b required 1 0 0 0 0 0",
        ifa.end_to_previous, ifa.ifm_enable_read, ifa.ifm_address_read, ifa.ifm_enable_write_next,
        ifa.ifm_address_write_next, ifa.ifm_sel_next);
    end
    tick(1);
    reset = 1'b0;
    wb = wr_q_a.size(); sb = stn_a;
    tick(100);
    checks++;
    if (wr_q_a.size() !== wb || stn_a !== sb) begin
      errors++; $display("FAIL rst_mid_quiet: got writes=%0d pulses=%0d required 0 0", wr_q_a.size() - wb, stn_a - sb);
    end
    start_a(ok);
    wait_stn_a(1200, ok);
    exp_sel_a = ~exp_sel_a;
    tick(3);
    checks++;
    if (wr_q_a.size() - wb !== 196 || ifa.ifm_sel_next !== exp_sel_a) begin
      errors++; $display("FAIL rst_mid_restart: got writes=%0d sel=%b required 196 and %b",
        wr_q_a.size() - wb, ifa.ifm_sel_next, exp_sel_a);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int wb;
    logic [31:0] first, last;
    do_reset();
    exp_sel_a = 1'b0;
    ifa.end_from_next = 1'b1;
    for (int f = 0; f < 2; f++) begin
      wb = wr_q_a.size();
      start_a(ok);
      wait_stn_a(1200, ok);
      exp_sel_a = ~exp_sel_a;
      tick(3);
      first = (wr_q_a.size() > wb) ? wr_q_a[wb] : 32'hffff_ffff;
      last  = (wr_q_a.size() > wb) ? wr_q_a[wr_q_a.size()-1] : 32'hffff_ffff;
      checks++;
      if (wr_q_a.size() - wb !== 196 || first !== 32'd0 || last !== 32'd195) begin
        errors++; $display("FAIL b2b_frame%0d_writes: got n=%0d first=%0d last=%0d required 196 0 195",
          f, wr_q_a.size() - wb, first, last);
      end
      checks++;
      if (ifa.ifm_sel_next !== exp_sel_a) begin
        errors++; $display("FAIL b2b_frame%0d_sel: got %b required %b", f, ifa.ifm_sel_next, exp_sel_a);
      end
    end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_default_frame();
    test_window_7x3x2();
    test_k1_passthrough();
    test_backpressure();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
